axis_fifo_pair_param: RTL

Parametrised successor to the fixed 16-bit/512-word AXI-Stream FIFO pair in the DMA datapath. It buffers the MM2S stream (DMA → processing) and the S2MM stream (processing → DMA) in two independent in-house FIFOs, with no vendor macro. Width, depth and almost-full threshold are configurable. Each direction reports its occupancy, the number of complete packets it holds, and an almost-full flag. An optional packet mode holds each output until a whole packet is stored.

---
 rtl/axis_fifo_pair_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axis_fifo_pair_param.sv
// rtl/axis_fifo_pair_param.sv - parametrised MM2S/S2MM AXI-Stream FIFO pair with occupancy, packet count and almost-full
//
// Optional feature macro: AXIS_FIFO_PACKET_MODE_EN
//   defined   : each read side holds tvalid low until a whole packet (tlast) is
//               stored, or until the FIFO is full so over-long packets drain.
//   undefined : read side is valid whenever the FIFO holds a word.
//
// axis_fifo_pair_param_chan ports:
//   aclk, aresetn                    clock, async active-low reset
//   s_tready/s_tdata/s_tvalid/s_tlast write side
//   m_tready/m_tdata/m_tvalid/m_tlast first-word-fall-through read side
//   data_count, pkt_count            stored words / stored tlast words
//   almost_full                      data_count >= AF_THRESH
//
// axis_fifo_pair_param ports:
//   aclk, aresetn                               clock, async active-low reset
//   s_axis_*  -> mm2s_*                         MM2S channel (DMA -> processing)
//   mm2s_data_count/pkt_count/almost_full       MM2S status
//   s2mm_*    -> m_axis_*                       S2MM channel (processing -> DMA)
//   s2mm_data_count/pkt_count/almost_full       S2MM status

module axis_fifo_pair_param_chan #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 512,
    parameter int AF_THRESH  = DEPTH - 8,
    parameter int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic [CW-1:0]         data_count,
    output logic [CW-1:0]         pkt_count,
    output logic                  almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count_q, count_d, pkt_q, pkt_d;
    logic                ready_q, af_q;
    logic                full, empty, wr_en, rd_en;

    assign full  = (count_q == FULL_C);
    assign empty = (count_q == '0);

    // ready_q keeps tready low during reset and for the edge that releases it.
    assign s_tready = ready_q && !full;

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // The full override lets a packet longer than the FIFO drain instead of deadlocking.
    assign m_tvalid = !empty && ((pkt_q != '0) || full);
`else
    assign m_tvalid = !empty;
`endif

    assign m_tdata = mem[rd_ptr][DATA_WIDTH-1:0];
    assign m_tlast = mem[rd_ptr][DATA_WIDTH];

    assign wr_en = s_tvalid && s_tready;
    assign rd_en = m_tvalid && m_tready;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        pkt_d = pkt_q;
        if ((wr_en && s_tlast) && !(rd_en && m_tlast)) begin
            pkt_d = pkt_q + CW'(1);
        end else if ((rd_en && m_tlast) && !(wr_en && s_tlast)) begin
            pkt_d = pkt_q - CW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            pkt_q   <= '0;
            af_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_d;
            pkt_q   <= pkt_d;
            af_q    <= (count_d >= AF_C);
        end
    end

    // Storage is not reset; pointer reset is what discards the contents.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    assign data_count  = count_q;
    assign pkt_count   = pkt_q;
    assign almost_full = af_q;
endmodule

module axis_fifo_pair_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 512,
    parameter int AF_THRESH  = DEPTH - 8,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  mm2s_tready,
    output logic [DATA_WIDTH-1:0] mm2s_tdata,
    output logic                  mm2s_tvalid,
    output logic                  mm2s_tlast,
    output logic [CW-1:0]         mm2s_data_count,
    output logic [CW-1:0]         mm2s_pkt_count,
    output logic                  mm2s_almost_full,
    output logic                  s2mm_tready,
    input  logic [DATA_WIDTH-1:0] s2mm_tdata,
    input  logic                  s2mm_tvalid,
    input  logic                  s2mm_tlast,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [CW-1:0]         s2mm_data_count,
    output logic [CW-1:0]         s2mm_pkt_count,
    output logic                  s2mm_almost_full
);
    axis_fifo_pair_param_chan #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .CW(CW)
    ) u_mm2s (
        .aclk(aclk), .aresetn(aresetn),
        .s_tready(s_axis_tready), .s_tdata(s_axis_tdata),
        .s_tvalid(s_axis_tvalid), .s_tlast(s_axis_tlast),
        .m_tready(mm2s_tready), .m_tdata(mm2s_tdata),
        .m_tvalid(mm2s_tvalid), .m_tlast(mm2s_tlast),
        .data_count(mm2s_data_count), .pkt_count(mm2s_pkt_count),
        .almost_full(mm2s_almost_full)
    );

    axis_fifo_pair_param_chan #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .CW(CW)
    ) u_s2mm (
        .aclk(aclk), .aresetn(aresetn),
        .s_tready(s2mm_tready), .s_tdata(s2mm_tdata),
        .s_tvalid(s2mm_tvalid), .s_tlast(s2mm_tlast),
        .m_tready(m_axis_tready), .m_tdata(m_axis_tdata),
        .m_tvalid(m_axis_tvalid), .m_tlast(m_axis_tlast),
        .data_count(s2mm_data_count), .pkt_count(s2mm_pkt_count),
        .almost_full(s2mm_almost_full)
    );
endmodule
